// File: rtl/fwrisc_cmp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fwrisc_cmp_arbiter_if
// Description : Request/response bundle for one requester of the comparator.
// Revision    : 1.0
// ============================================================================
interface fwrisc_cmp_arbiter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_result;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface
`default_nettype wire

// File: rtl/fwrisc_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fwrisc_cmp_arbiter
// Description : Two-requester arbiter in front of one shared EQ/LT/LTU
//               comparator. FWRISC_CMP_ARB_RR_EN selects round-robin
//               arbitration; otherwise requester 0 has fixed priority.
// Revision    : 1.0
// ============================================================================
module fwrisc_cmp_arbiter (
    input  logic                 clock,
    input  logic                 reset,
    fwrisc_cmp_arbiter_if.slave  req0,
    fwrisc_cmp_arbiter_if.slave  req1
);

    localparam logic [1:0] OP_EQ = 2'b00;
    localparam logic [1:0] OP_LT = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic        r_gnt;
    logic        r_result;

    logic        w_any;
    logic        w_winner;
    logic        w_accept;
    logic        w_rsp_take;
    logic        w_cmp;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic [1:0]  w_sel_op;

`ifdef FWRISC_CMP_ARB_RR_EN
    // Holds the requester favoured on the next conflict.
    logic        r_ptr;
`endif

    always_comb begin
        w_any = req0.req_valid | req1.req_valid;
`ifdef FWRISC_CMP_ARB_RR_EN
        if (req0.req_valid && req1.req_valid)
            w_winner = r_ptr;
        else
            w_winner = ~req0.req_valid;
`else
        w_winner = ~req0.req_valid;
`endif
        w_accept   = (r_state == ST_IDLE) && w_any && !reset;
        w_rsp_take = r_gnt ? req1.rsp_ready : req0.rsp_ready;
        w_sel_a    = w_winner ? req1.req_a  : req0.req_a;
        w_sel_b    = w_winner ? req1.req_b  : req0.req_b;
        w_sel_op   = w_winner ? req1.req_op : req0.req_op;
    end

    // The one shared comparator; op 2'b11 falls into the unsigned case.
    always_comb begin
        case (r_op)
            OP_EQ:   w_cmp = (r_a == r_b);
            OP_LT:   w_cmp = ($signed(r_a) < $signed(r_b));
            default: w_cmp = (r_a < r_b);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)      w_state_nxt = ST_CMP;
            ST_CMP:                  w_state_nxt = ST_RSP;
            ST_RSP:  if (w_rsp_take) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_op     <= 2'd0;
            r_gnt    <= 1'b0;
            r_result <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_op  <= w_sel_op;
                r_gnt <= w_winner;
            end
            if (r_state == ST_CMP)
                r_result <= w_cmp;
        end
    end

`ifdef FWRISC_CMP_ARB_RR_EN
    always_ff @(posedge clock) begin
        if (reset)
            r_ptr <= 1'b0;
        else if (w_accept)
            r_ptr <= ~w_winner;
    end
`endif

    assign req0.req_ready  = w_accept && !w_winner;
    assign req1.req_ready  = w_accept &&  w_winner;
    assign req0.rsp_valid  = (r_state == ST_RSP) && !r_gnt;
    assign req1.rsp_valid  = (r_state == ST_RSP) &&  r_gnt;
    assign req0.rsp_result = (r_state == ST_RSP) && !r_gnt && r_result;
    assign req1.rsp_result = (r_state == ST_RSP) &&  r_gnt && r_result;

endmodule
`default_nettype wire

// File: doc/fwrisc_cmp_arbiter.md
FWRISC_CMP_ARBITER -- requirements
Module: fwrisc_cmp_arbiter

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits, op width 2 bits.
REQ-002 SHALL have ports:
- clock  input  1  sole clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
REQ-003 SHALL have, per requester N in {0,1} (0 = branch unit, 1 = SLT/SLTU unit):
- reqN_valid   input   1   request present.
- reqN_ready   output  1   request accepted this cycle.
- reqN_a       input   32  operand A.
- reqN_b       input   32  operand B.
- reqN_op      input   2   compare op: EQ, LT (signed), LTU; encoding 2'b11 treated as LTU.
- rspN_valid   output  1   result available.
- rspN_ready   input   1   requester takes result.
- rspN_result  output  1   comparison result.
REQ-004 SHALL contain exactly one shared comparator (EQ / signed LT / unsigned LT); no second compare path.

Function
REQ-005 SHALL implement FSM states IDLE, CMP, RSP; reset state IDLE.
REQ-006 IDLE: if any reqN_valid, SHALL select one winner, assert its reqN_ready combinationally in the same cycle, latch a/b/op and grant index, go to CMP.
REQ-007 reqN_ready SHALL be 0 outside IDLE and for the non-winner; a request counts as accepted only when valid and ready are both 1.
REQ-008 CMP: SHALL drive latched operands through the comparator, register the result, go to RSP (exactly one cycle).
REQ-009 RSP: SHALL hold rspG_valid=1 and stable rspG_result for granted G until rspG_ready=1; on that cycle return to IDLE.
REQ-010 rsp of the non-granted requester SHALL be 0 at all times.
REQ-011 Latency: acceptance at cycle T -> rsp_valid first high at T+2; back-to-back throughput SHALL be one compare per 3 cycles with rsp_ready held high.
REQ-012 rspN_ready while rspN_valid=0 SHALL be ignored.
REQ-013 Operand or op changes on reqN_* after acceptance SHALL NOT affect the in-flight result.
REQ-014 Simultaneous req0_valid and req1_valid in IDLE SHALL be resolved per REQ-019/REQ-020; the loser keeps valid and is served on a later IDLE.
REQ-015 Request valid arriving during CMP or RSP SHALL be held off (ready=0), not dropped.

Reset
REQ-016 On reset: state=IDLE, all reqN_ready=0 during reset cycle, rspN_valid=0, rspN_result=0, latched operands=0, round-robin pointer=0 (favour requester 0).
REQ-017 Reset in CMP or RSP SHALL abandon the in-flight compare; no response is produced for it.
REQ-018 Reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-019 With FWRISC_CMP_ARB_RR_EN defined: round-robin; on conflict the requester not granted most recently wins; pointer updates on each accept.
REQ-020 Without FWRISC_CMP_ARB_RR_EN: fixed priority, requester 0 always wins on conflict; no pointer register exists.

Verification
REQ-021 Single req0: a=5, b=5, op=EQ accepted at T -> rsp0_valid at T+2, result=1; rsp1_valid stays 0.
REQ-022 req1: a=32'hFFFFFFFF, b=1, op=LT -> result=1; same with op=LTU -> result=0; op=2'b11 -> result=0.
REQ-023 Both valid continuously, rsp_ready=1: RR build grants 0,1,0,1; fixed build grants 0 repeatedly, 1 starved while 0 valid.
REQ-024 rsp0_ready held 0 for 4 cycles in RSP -> rsp0_valid/result stable, req0_ready/req1_ready stay 0, then release -> IDLE next cycle.
REQ-025 Change req0_a from 3 to 9 (b=7, op=LTU) the cycle after acceptance -> result=1 (uses 3).
REQ-026 Assert reset in CMP -> next cycle IDLE, rsp valids 0, no response for abandoned request; new request after reset served normally.
